// File: rtl/vmproj_mem_pkg.sv
// Shared widths, data layout and counter helper for the paged VM-projection buffer.
// Used by vmproj_page_counter and vmproj_mem_buffer.
package vmproj_mem_pkg;

    localparam int RAM_WIDTH  = 21;
    localparam int NENT_WIDTH = 8;
    localparam int PAGE_SIZE  = 128;

    typedef logic [NENT_WIDTH-1:0] nent_t;

    // Barrel PS VM projection word, MSB first.
    typedef struct packed {
        logic [6:0] index;
        logic [6:0] rinv;
        logic [3:0] zbin;
        logic [2:0] finephi;
    } vmproj_data_t;

    // Write counters stop at a full page; further writes overwrite in place.
    function automatic nent_t sat_inc(input nent_t count);
        if (count >= nent_t'(PAGE_SIZE)) begin
            return nent_t'(PAGE_SIZE);
        end
        return count + nent_t'(1);
    endfunction

endpackage

// File: rtl/vmproj_page_counter.sv
// Per-page write counter and nentries register: start clear, saturating count,
// and a compare pulse when the reported nentries disagrees with the counted writes.
module vmproj_page_counter
    import vmproj_mem_pkg::*;
(
    input  logic  clk,
    input  logic  reset,
    input  logic  i_start,
    input  logic  i_wr,
    input  logic  i_nent_we,
    input  nent_t i_nent_din,
    output nent_t o_nent,
    output logic  o_mismatch
);

    nent_t r_wcnt;
    nent_t r_nent;
    nent_t w_wcnt_next;

    // Clear happens before counting so start+write in one cycle leaves 1.
    always_comb begin
        // NOTE: every always_comb output gets a default first; a missed branch would infer a latch.
        w_wcnt_next = i_start ? '0 : r_wcnt;
        if (i_wr) begin
            w_wcnt_next = sat_inc(w_wcnt_next);
        end
    end

    assign o_mismatch = i_nent_we && !i_start && (i_nent_din != w_wcnt_next);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wcnt <= '0;
            r_nent <= '0;
        end else begin
            r_wcnt <= w_wcnt_next;
            if (i_nent_we) begin
                r_nent <= i_nent_din;
            end else if (i_start) begin
                r_nent <= '0;
            end
        end
    end

    assign o_nent = r_nent;

endmodule

// File: rtl/vmproj_mem_buffer.sv
// Paged VM-projection memory between a ProjectionRouter write port and a MatchEngine read port.
// Optional macro VMPROJ_MEM_OUTREG_EN adds a second output register (read latency 2).
module vmproj_mem_buffer #(
    parameter int RAM_WIDTH  = vmproj_mem_pkg::RAM_WIDTH,
    parameter int RAM_DEPTH  = 256,
    parameter int NUM_PAGES  = 2,
    parameter int ADDR_WIDTH = 8,
    parameter int NENT_WIDTH = vmproj_mem_pkg::NENT_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [2:0]            bx,
    input  logic                  wea,
    input  logic [ADDR_WIDTH-1:0] writeaddr,
    input  logic [RAM_WIDTH-1:0]  din,
    input  logic                  nentries_0_we,
    input  logic [NENT_WIDTH-1:0] nentries_0_din,
    input  logic                  nentries_1_we,
    input  logic [NENT_WIDTH-1:0] nentries_1_din,
    input  logic                  enb,
    input  logic [ADDR_WIDTH-1:0] readaddr,
    output logic [RAM_WIDTH-1:0]  dout,
    output logic [NENT_WIDTH-1:0] nentries_0_dout,
    output logic [NENT_WIDTH-1:0] nentries_1_dout,
    output logic                  wcount_mismatch
);

    localparam int PAGE_BITS = $clog2(NUM_PAGES);

    logic [PAGE_BITS-1:0]  w_wr_page;
    logic [PAGE_BITS-1:0]  w_bx_page;
    logic [NUM_PAGES-1:0]  w_nent_we;
    logic [NUM_PAGES-1:0]  w_mismatch;
    vmproj_mem_pkg::nent_t w_nent_din [NUM_PAGES];
    vmproj_mem_pkg::nent_t w_nent     [NUM_PAGES];
    logic                  w_unused_bx;

    assign w_wr_page   = writeaddr[ADDR_WIDTH-1 -: PAGE_BITS];
    assign w_bx_page   = bx[PAGE_BITS-1:0];
    assign w_unused_bx = ^bx[2:PAGE_BITS];

    assign w_nent_we     = {nentries_1_we, nentries_0_we};
    assign w_nent_din[0] = nentries_0_din;
    assign w_nent_din[1] = nentries_1_din;

    for (genvar p = 0; p < NUM_PAGES; p++) begin : g_page
        vmproj_page_counter u_cnt (
            .clk        (clk),
            .reset      (reset),
            .i_start    (start && (w_bx_page == PAGE_BITS'(p))),
            .i_wr       (wea && (w_wr_page == PAGE_BITS'(p))),
            .i_nent_we  (w_nent_we[p]),
            .i_nent_din (w_nent_din[p]),
            .o_nent     (w_nent[p]),
            .o_mismatch (w_mismatch[p])
        );
    end

    assign nentries_0_dout = w_nent[0];
    assign nentries_1_dout = w_nent[1];

    logic r_mismatch;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_mismatch <= 1'b0;
        end else if (|w_mismatch) begin
            r_mismatch <= 1'b1;
        end
    end

    assign wcount_mismatch = r_mismatch;

    logic [RAM_WIDTH-1:0] r_mem [RAM_DEPTH];
    logic [RAM_WIDTH-1:0] r_rd;

    // NOTE: the storage array has no reset so it maps onto block RAM; only the read register resets.
    always_ff @(posedge clk) begin
        if (wea) begin
            r_mem[writeaddr] <= din;
        end
    end

    // NOTE: non-blocking assignment samples the pre-edge array, giving read-first on a same-address write.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rd <= '0;
        end else if (enb) begin
            r_rd <= r_mem[readaddr];
        end
    end

`ifdef VMPROJ_MEM_OUTREG_EN
    logic                 r_enb_d;
    logic [RAM_WIDTH-1:0] r_dout_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_enb_d  <= 1'b0;
            r_dout_q <= '0;
        end else begin
            r_enb_d <= enb;
            if (r_enb_d) begin
                r_dout_q <= r_rd;
            end
        end
    end

    assign dout = r_dout_q;
`else
    assign dout = r_rd;
`endif

endmodule

// File: tb/tb_vmproj_mem_buffer.sv
// Self-checking bench for vmproj_mem_buffer: directed vector table, hand-written
// corner sequences, then randomized traffic against a behavioural model.
module tb_vmproj_mem_buffer;

`ifdef VMPROJ_MEM_OUTREG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  bx;
    logic        wea;
    logic [7:0]  writeaddr;
    logic [20:0] din;
    logic        nentries_0_we;
    logic [7:0]  nentries_0_din;
    logic        nentries_1_we;
    logic [7:0]  nentries_1_din;
    logic        enb;
    logic [7:0]  readaddr;
    logic [20:0] dout;
    logic [7:0]  nentries_0_dout;
    logic [7:0]  nentries_1_dout;
    logic        wcount_mismatch;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    vmproj_mem_buffer dut (
        .clk             (clk),
        .reset           (reset),
        .start           (start),
        .bx              (bx),
        .wea             (wea),
        .writeaddr       (writeaddr),
        .din             (din),
        .nentries_0_we   (nentries_0_we),
        .nentries_0_din  (nentries_0_din),
        .nentries_1_we   (nentries_1_we),
        .nentries_1_din  (nentries_1_din),
        .enb             (enb),
        .readaddr        (readaddr),
        .dout            (dout),
        .nentries_0_dout (nentries_0_dout),
        .nentries_1_dout (nentries_1_dout),
        .wcount_mismatch (wcount_mismatch)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic idle_inputs();
        start = 0; bx = 0; wea = 0; writeaddr = 0; din = 0;
        nentries_0_we = 0; nentries_0_din = 0; nentries_1_we = 0; nentries_1_din = 0;
        enb = 0; readaddr = 0;
    endtask

    // One clock; outputs are sampled 1 time unit after the rising edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // ---------------- directed vector table ----------------
    typedef struct packed {
        logic        start;
        logic [2:0]  bx;
        logic        wea;
        logic [7:0]  waddr;
        logic [20:0] din;
        logic        n0we;
        logic [7:0]  n0din;
        logic        n1we;
        logic [7:0]  n1din;
        logic        enb;
        logic [7:0]  raddr;
        logic        chk_dout;
        logic [20:0] e_dout;
        logic [7:0]  e_n0;
        logic [7:0]  e_n1;
        logic        e_mm;
    } vec_t;

    localparam int NVEC = 21;
    vec_t vecs [NVEC];

    function automatic vec_t row(input logic st, input logic [2:0] b, input logic w, input logic [7:0] wa,
                                 input logic [20:0] d, input logic n0w, input logic [7:0] n0d,
                                 input logic n1w, input logic [7:0] n1d, input logic e, input logic [7:0] ra,
                                 input logic cd, input logic [20:0] ed, input logic [7:0] en0,
                                 input logic [7:0] en1, input logic emm);
        vec_t v;
        v = '{st, b, w, wa, d, n0w, n0d, n1w, n1d, e, ra, cd, ed, en0, en1, emm};
        return v;
    endfunction

    // ---------------- behavioural model ----------------
    logic [20:0] m_mem   [256];
    bit          m_valid [256];
    logic [7:0]  m_wcnt  [2];
    logic [7:0]  m_nent  [2];
    logic        m_mm;
    logic [20:0] m_d1, m_d2;
    logic        m_enb_d;

    task automatic model_reset();
        for (int p = 0; p < 2; p++) begin
            m_wcnt[p] = 0;
            m_nent[p] = 0;
        end
        m_mm = 0; m_d1 = 0; m_d2 = 0; m_enb_d = 0;
    endtask

    // Number of writes page p will hold after this cycle's start/write.
    function automatic logic [7:0] post_cnt(input int p);
        logic [7:0] c;
        c = (start && bx[0] == p[0]) ? 8'd0 : m_wcnt[p];
        if (wea && writeaddr[7] == p[0] && c < 8'd128) c = c + 8'd1;
        return c;
    endfunction

    task automatic model_edge();
        logic [7:0] nc [2];
        logic       nwe;
        logic [7:0] nd;
        for (int p = 0; p < 2; p++) nc[p] = post_cnt(p);
        for (int p = 0; p < 2; p++) begin
            nwe = (p == 0) ? nentries_0_we  : nentries_1_we;
            nd  = (p == 0) ? nentries_0_din : nentries_1_din;
            if (nwe) begin
                m_nent[p] = nd;
                if (!(start && bx[0] == p[0]) && nd != nc[p]) m_mm = 1;
            end else if (start && bx[0] == p[0]) begin
                m_nent[p] = 0;
            end
            m_wcnt[p] = nc[p];
        end
        if (m_enb_d) m_d2 = m_d1;
        m_enb_d = enb;
        if (enb) m_d1 = m_mem[readaddr];
        if (wea) begin
            m_mem[writeaddr]   = din;
            m_valid[writeaddr] = 1;
        end
    endtask

    function automatic logic [20:0] exp_dout();
        return (LAT == 2) ? m_d2 : m_d1;
    endfunction

    initial begin
        idle_inputs();
        reset = 1'b0;

        // Reset: outputs held at zero even with a read requested.
        enb = 1; readaddr = 8'h05;
        for (int i = 0; i < 3; i++) begin
            cyc();
            check("reset_dout", dout, 0);
            check("reset_n0", nentries_0_dout, 0);
            check("reset_n1", nentries_1_dout, 0);
            check("reset_mm", wcount_mismatch, 0);
        end
        reset = 1'b1;
        idle_inputs();

        //              st bx w  waddr  din       n0 d  n1 d  e  raddr chk edout     en0 en1 mm
        vecs[0]  = row(1, 0, 0, 8'h00, 21'h0,     0, 0, 0, 0, 0, 8'h00, 0, 21'h0,     0,  0,  0);
        vecs[1]  = row(0, 0, 1, 8'h00, 21'h1AAAA, 0, 0, 0, 0, 0, 8'h00, 0, 21'h0,     0,  0,  0);
        vecs[2]  = row(0, 0, 1, 8'h01, 21'h1BBBB, 0, 0, 0, 0, 0, 8'h00, 0, 21'h0,     0,  0,  0);
        vecs[3]  = row(0, 0, 1, 8'h02, 21'h1CCCC, 0, 0, 0, 0, 0, 8'h00, 0, 21'h0,     0,  0,  0);
        vecs[4]  = row(0, 0, 0, 8'h00, 21'h0,     1, 3, 0, 0, 0, 8'h00, 1, 21'h0,     3,  0,  0);
        vecs[5]  = row(0, 0, 0, 8'h00, 21'h0,     0, 0, 0, 0, 1, 8'h01, 0, 21'h0,     3,  0,  0);
        vecs[6]  = row(0, 0, 0, 8'h00, 21'h0,     0, 0, 0, 0, 0, 8'h00, 0, 21'h0,     3,  0,  0);
        vecs[7]  = row(0, 0, 0, 8'h00, 21'h0,     0, 0, 0, 0, 0, 8'h00, 1, 21'h1BBBB, 3,  0,  0);
        vecs[8]  = row(1, 1, 0, 8'h00, 21'h0,     0, 0, 0, 0, 0, 8'h00, 0, 21'h0,     3,  0,  0);
        vecs[9]  = row(0, 0, 1, 8'h80, 21'h00011, 0, 0, 0, 0, 0, 8'h00, 0, 21'h0,     3,  0,  0);
        vecs[10] = row(0, 0, 1, 8'h81, 21'h00022, 0, 0, 0, 0, 0, 8'h00, 0, 21'h0,     3,  0,  0);
        vecs[11] = row(0, 0, 0, 8'h00, 21'h0,     0, 0, 1, 5, 0, 8'h00, 0, 21'h0,     3,  5,  1);
        vecs[12] = row(0, 0, 0, 8'h00, 21'h0,     0, 0, 1, 2, 0, 8'h00, 0, 21'h0,     3,  2,  1);
        vecs[13] = row(0, 0, 0, 8'h00, 21'h0,     0, 0, 0, 0, 0, 8'h00, 0, 21'h0,     3,  2,  1);
        vecs[14] = row(0, 0, 1, 8'h10, 21'h1FFFF, 0, 0, 0, 0, 0, 8'h00, 0, 21'h0,     3,  2,  1);
        vecs[15] = row(0, 0, 1, 8'h10, 21'h00123, 0, 0, 0, 0, 1, 8'h10, 0, 21'h0,     3,  2,  1);
        vecs[16] = row(0, 0, 0, 8'h00, 21'h0,     0, 0, 0, 0, 0, 8'h00, 0, 21'h0,     3,  2,  1);
        vecs[17] = row(0, 0, 0, 8'h00, 21'h0,     0, 0, 0, 0, 0, 8'h00, 1, 21'h1FFFF, 3,  2,  1);
        vecs[18] = row(0, 0, 0, 8'h00, 21'h0,     0, 0, 0, 0, 1, 8'h10, 0, 21'h0,     3,  2,  1);
        vecs[19] = row(0, 0, 0, 8'h00, 21'h0,     0, 0, 0, 0, 0, 8'h00, 0, 21'h0,     3,  2,  1);
        vecs[20] = row(0, 0, 0, 8'h00, 21'h0,     0, 0, 0, 0, 0, 8'h00, 1, 21'h00123, 3,  2,  1);

        for (int i = 0; i < NVEC; i++) begin
            start = vecs[i].start; bx = vecs[i].bx; wea = vecs[i].wea;
            writeaddr = vecs[i].waddr; din = vecs[i].din;
            nentries_0_we = vecs[i].n0we; nentries_0_din = vecs[i].n0din;
            nentries_1_we = vecs[i].n1we; nentries_1_din = vecs[i].n1din;
            enb = vecs[i].enb; readaddr = vecs[i].raddr;
            cyc();
            if (vecs[i].chk_dout) check($sformatf("vec%0d_dout", i), dout, vecs[i].e_dout);
            check($sformatf("vec%0d_n0", i), nentries_0_dout, vecs[i].e_n0);
            check($sformatf("vec%0d_n1", i), nentries_1_dout, vecs[i].e_n1);
            check($sformatf("vec%0d_mm", i), wcount_mismatch, vecs[i].e_mm);
        end
        idle_inputs();

        // Sticky flag clears only on reset.
        reset = 1'b0;
        cyc();
        check("mm_cleared_by_reset", wcount_mismatch, 0);
        reset = 1'b1;

        // Saturation: 130 writes into page 0, count tops out at 128.
        start = 1; bx = 0;
        cyc();
        start = 0;
        for (int i = 0; i < 130; i++) begin
            wea = 1; writeaddr = 8'(i % 128); din = 21'(i);
            cyc();
        end
        wea = 0;
        nentries_0_we = 1; nentries_0_din = 8'd128;
        cyc();
        nentries_0_we = 0;
        check("sat_n0", nentries_0_dout, 128);
        check("sat_mm", wcount_mismatch, 0);

        start = 1; bx = 1;
        cyc();
        start = 0; wea = 1; writeaddr = 8'h85; din = 21'h5;
        cyc();
        wea = 0; nentries_1_we = 1; nentries_1_din = 8'd1;
        cyc();
        nentries_1_we = 0;
        check("p1_n1", nentries_1_dout, 1);

        // bx=2 selects page 0 again; page 1 untouched.
        start = 1; bx = 3'd2;
        cyc();
        start = 0;
        check("bx2_n0", nentries_0_dout, 0);
        check("bx2_n1", nentries_1_dout, 1);
        check("bx2_mm", wcount_mismatch, 0);

        // start and write to the same page in one cycle: count ends at 1.
        start = 1; bx = 0; wea = 1; writeaddr = 8'h05; din = 21'h7;
        cyc();
        start = 0; wea = 0; nentries_0_we = 1; nentries_0_din = 8'd1;
        cyc();
        nentries_0_we = 0;
        check("startwr_n0", nentries_0_dout, 1);
        check("startwr_mm", wcount_mismatch, 0);

        // nentries and start together: nentries wins, no compare.
        start = 1; bx = 0; nentries_0_we = 1; nentries_0_din = 8'd77;
        cyc();
        start = 0; nentries_0_din = 8'd0;
        check("startnent_n0", nentries_0_dout, 77);
        check("startnent_mm", wcount_mismatch, 0);
        cyc();
        nentries_0_we = 0;
        check("startnent_cleared_mm", wcount_mismatch, 0);

        // Mid-event reset.
        enb = 1; readaddr = 8'h05;
        cyc();
        enb = 0;
        cyc();
        cyc();
        check("pre_reset_dout", dout, 21'h7);
        start = 1; bx = 0;
        cyc();
        start = 0; wea = 1; writeaddr = 8'h20; din = 21'h11;
        cyc();
        writeaddr = 8'h21;
        cyc();
        wea = 0;
        #2 reset = 1'b0;
        #1;
        check("async_rst_dout", dout, 0);
        check("async_rst_n1", nentries_1_dout, 0);
        check("async_rst_mm", wcount_mismatch, 0);
        cyc();
        reset = 1'b1;
        nentries_0_we = 1; nentries_0_din = 8'd0;
        cyc();
        nentries_0_we = 0;
        check("post_rst_mm", wcount_mismatch, 0);
        check("post_rst_dout", dout, 0);

        // Randomized traffic against the model.
        idle_inputs();
        reset = 1'b0;
        model_reset();
        for (int a = 0; a < 256; a++) m_valid[a] = 0;
        cyc();
        reset = 1'b1;
        for (int c = 0; c < 2000; c++) begin
            if (c % 250 == 249) begin
                reset = 1'b0;
                model_reset();
                cyc();
                reset = 1'b1;
            end
            start = ($urandom_range(0, 15) == 0);
            bx = 3'($urandom);
            wea = 1'($urandom_range(0, 1));
            writeaddr = 8'($urandom);
            din = 21'($urandom);
            nentries_0_we = ($urandom_range(0, 5) == 0);
            nentries_1_we = ($urandom_range(0, 5) == 0);
            nentries_0_din = ($urandom_range(0, 7) == 0) ? 8'($urandom) : post_cnt(0);
            nentries_1_din = ($urandom_range(0, 7) == 0) ? 8'($urandom) : post_cnt(1);
            readaddr = ($urandom_range(0, 1) == 1) ? writeaddr : 8'($urandom);
            enb = ($urandom_range(0, 2) != 0) && m_valid[readaddr];
            @(posedge clk);
            model_edge();
            #1;
            check("rnd_dout", dout, exp_dout());
            check("rnd_n0", nentries_0_dout, m_nent[0]);
            check("rnd_n1", nentries_1_dout, m_nent[1]);
            check("rnd_mm", wcount_mismatch, m_mm);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/vmproj_mem_buffer.md
Name: vmproj_mem_buffer

Overview:
- Paged VM-projection memory that sits between one ProjectionRouter vmprojoutN write port and the MatchEngine read port.
- Stores 21-bit VM projections in NUM_PAGES bx-selected pages and holds one nentries register per page.
- Tracks the actual number of writes per page and flags any disagreement with the nentries value the router reports.
- Provides a registered read port matching the router/ME memory convention: address in, data one cycle later.

Parameters:
- RAM_WIDTH, 21, data word width (VM projection, barrel PS)
- RAM_DEPTH, 256, total words across all pages
- NUM_PAGES, 2, number of bx pages; page size = RAM_DEPTH/NUM_PAGES = 128
- ADDR_WIDTH, 8, log2(RAM_DEPTH); page = addr[ADDR_WIDTH-1 -: log2(NUM_PAGES)]
- NENT_WIDTH, 8, nentries width

Ports:
- clk  in  1  single clock
- reset  in  1  asynchronous, active-low reset
- start  in  1  one-cycle new-event pulse, driven from the router's en_proc
- bx  in  3  event bx; bx[log2(NUM_PAGES)-1:0] selects the page cleared by start
- wea  in  1  write strobe (router dataarray_data_V_we0)
- writeaddr  in  ADDR_WIDTH  write address, page in MSBs
- din  in  RAM_WIDTH  write data
- nentries_0_we  in  1  page-0 nentries valid (router ap_vld)
- nentries_0_din  in  NENT_WIDTH  page-0 entry count
- nentries_1_we  in  1  page-1 nentries valid
- nentries_1_din  in  NENT_WIDTH  page-1 entry count
- enb  in  1  read enable (ME ce0)
- readaddr  in  ADDR_WIDTH  read address
- dout  out  RAM_WIDTH  read data
- nentries_0_dout  out  NENT_WIDTH  page-0 stored count
- nentries_1_dout  out  NENT_WIDTH  page-1 stored count
- wcount_mismatch  out  1  sticky error: a reported nentries differed from the counted writes

Behaviour:
- Reset (reset=0, asynchronous assert, synchronous-release flops):
  - dout=0, nentries_*_dout=0, all write counters=0, wcount_mismatch=0.
  - Memory contents are not reset.
  - Asserting reset mid-event clears the above immediately; writes in flight are lost.
- Write:
  - When wea=1, mem[writeaddr]<=din at the clock edge.
  - The counter wcnt[page(writeaddr)] increments, saturating at page size (128).
  - Writes to any address are accepted; no bounds check.
- Start:
  - When start=1, wcnt[p] and nent[p] are cleared for p=bx page.
  - The other page is untouched.
  - start and wea to the same page in the same cycle: the counter ends at 1 (clear then count).
- Nentries:
  - When nentries_p_we=1, nent[p]<=nentries_p_din, which drives nentries_p_dout from the next cycle.
  - In the same cycle, compare nentries_p_din with the post-update wcnt[p] (the value including any same-cycle write to page p). If they differ, wcount_mismatch<=1.
  - wcount_mismatch is sticky until reset.
  - nentries_p_we and start on the same page in the same cycle: the nentries write wins for nent[p]; wcnt is still cleared and no compare occurs.
- Read:
  - When enb=1, dout<=mem[readaddr] one cycle later (latency 1).
  - When enb=0, dout holds its value.
  - Same-address read and write in the same cycle is read-first: the old data is returned.
- Saturation:
  - A counter at 128 stays at 128.
  - The compare still runs; any nentries value other than 128 flags mismatch.
- No state machine beyond per-page counter and register control; all paths single-cycle.

Optional Feature:
- Macro: VMPROJ_MEM_OUTREG_EN.
- When defined:
  - An extra output register stage is added; read latency is 2.
  - The second stage loads only when enb, delayed by one cycle, is 1; otherwise it holds.
  - The extra register resets to 0.
- When undefined: latency is 1 as above, with no extra flops.

Decomposition:
- Package vmproj_mem_pkg holds:
  - RAM_WIDTH, NENT_WIDTH and PAGE_SIZE constants.
  - typedef vmproj_data_t (21-bit) with field slices for index, zbin and finephi.
  - typedef nent_t.
- One natural sub-module, vmproj_page_counter:
  - Contains the per-page write counter, start clear, saturation and nentries compare.
  - Instantiated NUM_PAGES times.
  - The top OR-reduces the per-page mismatch pulses into the sticky flag.

Test Plan:
- Reset then read addr 0x05 with enb=1 -> dout=0 and nentries_0/1_dout=0 throughout reset; mismatch=0.
- start with bx=0, then 3 writes to 0x00..0x02 (din 0x1AAAA, 0x1BBBB, 0x1CCCC), then nentries_0_we with din=3 -> nentries_0_dout=3, mismatch stays 0; read 0x01 returns 0x1BBBB after 1 cycle (2 cycles with VMPROJ_MEM_OUTREG_EN).
- start with bx=1, 2 writes to 0x80 and 0x81, then nentries_1_we with din=5 -> wcount_mismatch=1 and stays 1 across later correct reports until reset.
- Same cycle: wea to 0x10 din=0x00123 and enb to 0x10 (old 0x1FFFF) -> dout=0x1FFFF; next read of 0x10 -> 0x00123.
- 130 writes to page 0 then nentries_0_din=128 -> no mismatch (saturation); a second start with bx=2 -> nentries_0_dout=0 with page-1 values unchanged.
- Assert reset mid-sequence after 2 writes, release, then nentries_0_we with din=0 -> no mismatch; dout=0.
